mont_modmul_seq: RTL
====================

// Module: mont_modmul_seq
// PURPOSE
//  Parametrised bit-serial radix-2 Montgomery modular multiplier with an internal sequencer.
//  Full mode: pass 1 M1 = A*B*R^-1 mod P, pass 2 M = M1*R2*R^-1 mod P = A*B mod P (R = 2^W).
//  Mont mode: pass 1 only, M = A*B*R^-1 mod P.
//  Standalone arithmetic engine for the ECC datapath. R2 is a runtime input, not a constant.
// PARAMETERS
//  W     256  operand/modulus width in bits; R = 2^W
//  CNT_W $clog2(W)+1  iteration counter width (derived; do not override)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  request; sampled only in IDLE
//  mont_only  in   1  1 = pass 1 only; 0 = both passes; sampled with start
//  A          in   W  multiplicand, must be < P; sampled with start
//  B          in   W  multiplier, must be < P; sampled with start
//  P          in   W  odd modulus; sampled with start
//  R2         in   W  R^2 mod P, used by pass 2; sampled with start
//  M          out  W  result; holds until the next done
//  done       out  1  one-cycle pulse; M is valid in the same cycle
//  busy       out  1  high from the cycle after start is accepted until done
//  err        out  1  one-cycle pulse with done on a rejected request (RANGE_CHECK only)
// BEHAVIOUR
//  Reset, async: M=0, done=0, busy=0, err=0, state=IDLE, all operand/accumulator regs 0.
//  Reset mid-operation aborts the operation. No result or done is produced.
//  FSM: IDLE -> PASS1 -> SUB1 -> (mont_only ? FIN : PASS2 -> SUB2 -> FIN) -> IDLE.
//   IDLE: start=1 latches A,B,P,R2,mont_only; S=0; cnt=0; busy<=1; next PASS1.
//   PASSx: one iteration per clock, cnt 0..W-1, a_i = latched multiplicand bit cnt (LSB first).
//    Iteration: T = S + (a_i ? Bop : 0); if T[0], T = T + P; S = T >> 1.
//    S and T are W+2 bits wide and never overflow. Invariant: S < 2P.
//    Leave PASSx after the iteration with cnt == W-1.
//   SUBx: S >= P ? S-P : S, giving a result in [0,P).
//    SUB1 with mont_only=0: load multiplicand = that result, Bop = R2; S=0; cnt=0; next PASS2.
//    SUB1 with mont_only=1, or SUB2: register the result into M; next FIN.
//   FIN: done=1 and busy=0 for this cycle; next IDLE.
//  done is also high in the first IDLE cycle after FIN; clear it the following cycle.
//  Latency, start edge to the done-high cycle:
//   full mode = 2W+3 cycles (W=256: 515)
//   mont mode = W+2 cycles
//  start while busy=1: ignored, no queueing, latched operands unaffected.
//  Back-to-back: start may be asserted in the cycle done is high; it is accepted (state is IDLE).
//  Input ports may change freely while busy; only the latched copies are used.
//  Without RANGE_CHECK, P even or A/B/R2 >= P gives an undefined M value.
//   Timing and handshake stay as specified regardless.
// CONFIGURATION
//  MONT_MODMUL_RANGE_CHECK_EN defined:
//   In IDLE, on start, check P[0]==0, A>=P, B>=P, or (!mont_only && R2>=P).
//   If any check is true: no computation; go straight to FIN; M<=0; done=1 and err=1 in that cycle.
//   Latency for a rejected request is 2 cycles.
//  Not defined: no comparators; err tied to 0; every start is computed.
// TESTING
//  T1 W=8, P=0xF1, R2=0xE1, A=2, B=3, mont_only=0 -> M=0x06, done exactly 19 cycles after start.
//  T2 W=8, P=0xF1, A=B=0x0F (R mod P), mont_only=1 -> M=0x0F, done 10 cycles after start.
//  T3 W=8, P=0xF1, R2=0xE1, A=B=0xF0, full mode -> M=0x01; back-to-back start on the done cycle
//     with A=5, B=7 -> M=0x23 after 19 more cycles.
//  T4 W=256, P=2^256-2^32-977, R2=0x1_000007A2_000E90A1, A=2, B=3 -> M=6 at 515 cycles.
//     A=P-1, B=P-1 -> M=1.
//  T5 start pulsed while busy (cycle 5), then rst_n low at cycle 9 of an active op
//     -> the start is ignored; after reset M=0, done=0, busy=0; a fresh T1 passes.
//  T6 (MONT_MODMUL_RANGE_CHECK_EN) W=8, P=0xF0 or A=0xF5 with P=0xF1 -> err=done=1 two cycles
//     after start, M=0. Without the macro, err stays 0.

Source files
------------

// File: rtl/mont_modmul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mont_modmul_seq                                              |
// | Description : Bit-serial radix-2 Montgomery modular multiplier with an     |
// |               internal sequencer. Full mode computes A*B mod P in two      |
// |               Montgomery passes (second pass multiplies by R2 = R^2 mod P).|
// |               Mont mode runs one pass and returns A*B*R^-1 mod P.          |
// | Options     : MONT_MODMUL_RANGE_CHECK_EN - reject requests with an even    |
// |               modulus or out-of-range operands (err pulse, M = 0).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mont_modmul_seq #(
  parameter int W     = 256,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mont_only,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] P,
  input  logic [W-1:0] R2,
  output logic [W-1:0] M,
  output logic         done,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS1 = 3'd1,
    ST_SUB1  = 3'd2,
    ST_PASS2 = 3'd3,
    ST_SUB2  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(W - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;      // multiplicand, shifted right once per iteration
  logic [W-1:0]     b_q, b_d;      // multiplier operand of the current pass
  logic [W-1:0]     p_q, p_d;
  logic [W-1:0]     r2_q, r2_d;
  logic             mont_q, mont_d;
  logic [W+1:0]     s_q, s_d;      // accumulator, kept below 2P
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     m_q, m_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [W+1:0]     t_add;
  logic [W+1:0]     t_red;
  logic [W+1:0]     s_next;
  logic             s_ge_p;
  logic [W-1:0]     sub_res;

`ifdef MONT_MODMUL_RANGE_CHECK_EN
  logic             rej_q, rej_d;
  logic             err_q, err_d;
  logic             bad_req;
`endif

  // Datapath: one Montgomery iteration and the final conditional subtraction
  always_comb begin
    t_add   = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_red   = t_add[0] ? (t_add + {2'b00, p_q}) : t_add;
    s_next  = t_red >> 1;
    s_ge_p  = (s_q >= {2'b00, p_q});
    // Result is below P < 2^W, so the low W bits of the difference suffice
    sub_res = s_ge_p ? (s_q[W-1:0] - p_q) : s_q[W-1:0];
  end

`ifdef MONT_MODMUL_RANGE_CHECK_EN
  // Request validity, evaluated on the latched operands in the first PASS1 cycle
  always_comb begin
    bad_req = ~p_q[0] | (a_q >= p_q) | (b_q >= p_q) | (~mont_q & (r2_q >= p_q));
  end
`endif

  // Sequencer next-state and register update logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r2_d    = r2_q;
    mont_d  = mont_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef MONT_MODMUL_RANGE_CHECK_EN
    rej_d   = rej_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          p_d     = P;
          r2_d    = R2;
          mont_d  = mont_only;
          s_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef MONT_MODMUL_RANGE_CHECK_EN
          rej_d   = 1'b0;
`endif
          state_d = ST_PASS1;
        end
      end
      ST_PASS1, ST_PASS2: begin
`ifdef MONT_MODMUL_RANGE_CHECK_EN
        if (state_q == ST_PASS1 && cnt_q == '0 && bad_req) begin
          m_d     = '0;
          rej_d   = 1'b1;
          state_d = ST_FIN;
        end else
`endif
        begin
          s_d   = s_next;
          a_d   = a_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == c_last_iter) begin
            state_d = (state_q == ST_PASS1) ? ST_SUB1 : ST_SUB2;
          end
        end
      end
      ST_SUB1: begin
        if (mont_q) begin
          m_d     = sub_res;
          state_d = ST_FIN;
        end else begin
          // Second pass multiplies the first result by R^2 mod P
          a_d     = sub_res;
          b_d     = r2_q;
          s_d     = '0;
          cnt_d   = '0;
          state_d = ST_PASS2;
        end
      end
      ST_SUB2: begin
        m_d     = sub_res;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef MONT_MODMUL_RANGE_CHECK_EN
        err_d   = rej_q;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r2_q    <= '0;
      mont_q  <= 1'b0;
      s_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MONT_MODMUL_RANGE_CHECK_EN
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r2_q    <= r2_d;
      mont_q  <= mont_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MONT_MODMUL_RANGE_CHECK_EN
      rej_q   <= rej_d;
      err_q   <= err_d;
`endif
    end
  end

  assign M    = m_q;
  assign done = done_q;
  assign busy = busy_q;
`ifdef MONT_MODMUL_RANGE_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule
`default_nettype wire
